// File: rtl/regfile_writeback_pkg.sv
// Shared kinds, register constants and FSM states for the register-file writeback stage.
package regfile_writeback_pkg;

  localparam int unsigned W_DEF   = 8;
  localparam int unsigned D_DEF   = 4;
  localparam int unsigned ACC_REG = 0;

  typedef enum logic [1:0] {
    KIND_ACC = 2'b00,
    KIND_SLL = 2'b01,
    KIND_ADD = 2'b10,
    KIND_MOV = 2'b11
  } kind_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_CARRY
  } wb_state_e;

  function automatic logic has_carry(input logic [1:0] kind);
    return (kind == KIND_SLL) || (kind == KIND_ADD);
  endfunction

  function automatic logic has_dst(input logic [1:0] kind);
    return (kind == KIND_SLL) || (kind == KIND_MOV);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Generic DEPTH x EW FIFO; exposes all entries oldest-first for the forwarding scan.
module wb_fifo #(
  parameter int unsigned EW    = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [EW-1:0]             wdata,
  output logic [EW-1:0]             head,
  output logic                      full,
  output logic                      empty,
  output logic [DEPTH-1:0][EW-1:0]  ordered,
  output logic [DEPTH-1:0]          ordered_valid
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ordered[i]       = mem[rd_ptr + AW'(i)];
      ordered_valid[i] = ((AW+1)'(i) < count);
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: buffers results and drives the register-file write port with read forwarding.
// Optional macro REGFILE_WB_SPLIT_CARRY_EN serializes data/carry writes for a single-port register file.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned D     = D_DEF,
  parameter int unsigned DEPTH = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_kind,
  input  logic [D-1:0] in_dst,
  input  logic [D-1:0] in_carry_dst,
  input  logic [W-1:0] in_data,
  input  logic         in_carry,
  input  logic         wb_stall,
  output logic         WriteEn,
  output logic         writeEnCarryOut,
  output logic [1:0]   addrFlag,
  output logic [D-1:0] Waddr,
  output logic [D-1:0] waddrCarryOut,
  output logic [W-1:0] DataIn,
  output logic         carryOutData,
  input  logic [D-1:0] fwd_raddr_a,
  input  logic [D-1:0] fwd_raddr_accum,
  output logic         fwd_hit_a,
  output logic [W-1:0] fwd_data_a,
  output logic         fwd_hit_accum,
  output logic [W-1:0] fwd_data_accum,
  output logic         busy
);

  localparam int unsigned EW = 2 + 2*D + W + 1;

  logic                     push, pop, full, empty;
  logic [EW-1:0]            head;
  logic [DEPTH-1:0][EW-1:0] ordered;
  logic [DEPTH-1:0]         ordered_valid;

  logic [1:0]   h_kind, f_kind;
  logic [D-1:0] h_dst, h_cdst, f_dst, f_cdst;
  logic [W-1:0] h_data, f_data;
  logic         h_carry, f_carry;

  function automatic logic [D-1:0] eff_dst(input logic [1:0] kind, input logic [D-1:0] dst);
    return has_dst(kind) ? dst : D'(ACC_REG);
  endfunction

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign {h_kind, h_dst, h_cdst, h_data, h_carry} = head;

  wb_fifo #(.EW(EW), .DEPTH(DEPTH)) u_fifo (
    .Clk           (Clk),
    .Reset         (Reset),
    .push          (push),
    .pop           (pop),
    .wdata         ({in_kind, in_dst, in_carry_dst, in_data, in_carry}),
    .head          (head),
    .full          (full),
    .empty         (empty),
    .ordered       (ordered),
    .ordered_valid (ordered_valid)
  );

  // Oldest-to-youngest scan so later hits override; carry checked after data so it wins per entry.
  always_comb begin
    fwd_hit_a      = 1'b0;
    fwd_data_a     = '0;
    fwd_hit_accum  = 1'b0;
    fwd_data_accum = '0;
    f_kind = '0; f_dst = '0; f_cdst = '0; f_data = '0; f_carry = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      {f_kind, f_dst, f_cdst, f_data, f_carry} = ordered[i];
      if (ordered_valid[i]) begin
        if (eff_dst(f_kind, f_dst) == fwd_raddr_a) begin
          fwd_hit_a  = 1'b1;
          fwd_data_a = f_data;
        end
        if (has_carry(f_kind) && (f_cdst == fwd_raddr_a)) begin
          fwd_hit_a  = 1'b1;
          fwd_data_a = W'(f_carry);
        end
        if (eff_dst(f_kind, f_dst) == fwd_raddr_accum) begin
          fwd_hit_accum  = 1'b1;
          fwd_data_accum = f_data;
        end
        if (has_carry(f_kind) && (f_cdst == fwd_raddr_accum)) begin
          fwd_hit_accum  = 1'b1;
          fwd_data_accum = W'(f_carry);
        end
      end
    end
  end

`ifndef REGFILE_WB_SPLIT_CARRY_EN

  always_comb begin
    WriteEn         = 1'b0;
    writeEnCarryOut = 1'b0;
    addrFlag        = '0;
    Waddr           = '0;
    waddrCarryOut   = '0;
    DataIn          = '0;
    carryOutData    = 1'b0;
    pop             = 1'b0;
    if (!empty && !wb_stall) begin
      WriteEn      = 1'b1;
      addrFlag     = h_kind;
      Waddr        = h_dst;
      DataIn       = h_data;
      carryOutData = h_carry;
      pop          = 1'b1;
      if (has_carry(h_kind)) begin
        writeEnCarryOut = 1'b1;
        waddrCarryOut   = h_cdst;
      end
    end
  end

  assign busy = !empty;

`else

  wb_state_e state, next_state, cur;

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // IDLE with a waiting entry acts as DATA in the same cycle, keeping one-cycle latency.
  always_comb begin
    WriteEn         = 1'b0;
    writeEnCarryOut = 1'b0;
    addrFlag        = '0;
    Waddr           = '0;
    waddrCarryOut   = '0;
    DataIn          = '0;
    carryOutData    = 1'b0;
    pop             = 1'b0;
    cur             = (state == S_IDLE && !empty) ? S_DATA : state;
    next_state      = cur;
    case (cur)
      S_DATA: if (!wb_stall) begin
        WriteEn  = 1'b1;
        addrFlag = KIND_MOV;
        Waddr    = eff_dst(h_kind, h_dst);
        DataIn   = h_data;
        if (has_carry(h_kind)) begin
          next_state = S_CARRY;
        end else begin
          pop        = 1'b1;
          next_state = ordered_valid[1] ? S_DATA : S_IDLE;
        end
      end
      S_CARRY: if (!wb_stall) begin
        WriteEn    = 1'b1;
        addrFlag   = KIND_MOV;
        Waddr      = h_cdst;
        DataIn     = W'(h_carry);
        pop        = 1'b1;
        next_state = ordered_valid[1] ? S_DATA : S_IDLE;
      end
      default: ;
    endcase
  end

  assign busy = !empty || (state != S_IDLE);

`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback against a queue-based reference model.
module tb_regfile_writeback;

  localparam int unsigned W     = 8;
  localparam int unsigned D     = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned PW    = 5 + 2*D + W;

  logic         Clk, Reset;
  logic         in_valid, in_ready, in_carry, wb_stall;
  logic [1:0]   in_kind, addrFlag;
  logic [D-1:0] in_dst, in_carry_dst, Waddr, waddrCarryOut, fwd_raddr_a, fwd_raddr_accum;
  logic [W-1:0] in_data, DataIn, fwd_data_a, fwd_data_accum;
  logic         WriteEn, writeEnCarryOut, carryOutData, fwd_hit_a, fwd_hit_accum, busy;
  logic [PW-1:0] wport;

  typedef struct {
    logic [1:0]   kind;
    logic [D-1:0] dst;
    logic [D-1:0] cdst;
    logic [W-1:0] data;
    logic         carry;
  } ent_t;

  ent_t q[$];
  bit   half_done;
  int   n_checks = 0;
  int   n_pass   = 0;

  regfile_writeback #(.W(W), .D(D), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_dst(in_dst), .in_carry_dst(in_carry_dst),
    .in_data(in_data), .in_carry(in_carry), .wb_stall(wb_stall),
    .WriteEn(WriteEn), .writeEnCarryOut(writeEnCarryOut), .addrFlag(addrFlag),
    .Waddr(Waddr), .waddrCarryOut(waddrCarryOut), .DataIn(DataIn),
    .carryOutData(carryOutData), .fwd_raddr_a(fwd_raddr_a),
    .fwd_raddr_accum(fwd_raddr_accum), .fwd_hit_a(fwd_hit_a),
    .fwd_data_a(fwd_data_a), .fwd_hit_accum(fwd_hit_accum),
    .fwd_data_accum(fwd_data_accum), .busy(busy)
  );

  assign wport = {WriteEn, writeEnCarryOut, addrFlag, Waddr, waddrCarryOut, DataIn, carryOutData};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic bit m_hc(input ent_t e);
    return (e.kind == 2'b01) || (e.kind == 2'b10);
  endfunction

  function automatic logic [D-1:0] m_eff(input ent_t e);
    logic [D-1:0] r;
    r = ((e.kind == 2'b01) || (e.kind == 2'b11)) ? e.dst : '0;
    return r;
  endfunction

  function automatic logic [PW-1:0] exp_wport();
    ent_t         e;
    logic [D-1:0] c, ed;
    logic [W-1:0] cv;
    if (q.size() == 0 || wb_stall) return '0;
    e  = q[0];
    ed = m_eff(e);
    cv = W'(e.carry);
    c  = m_hc(e) ? e.cdst : '0;
`ifdef REGFILE_WB_SPLIT_CARRY_EN
    if (!half_done) return {1'b1, 1'b0, 2'b11, ed, {D{1'b0}}, e.data, 1'b0};
    return {1'b1, 1'b0, 2'b11, e.cdst, {D{1'b0}}, cv, 1'b0};
`else
    return {1'b1, m_hc(e), e.kind, e.dst, c, e.data, e.carry};
`endif
  endfunction

  // Youngest entry first; within an entry the carry half is the later write.
  function automatic logic [W:0] exp_fwd(input logic [D-1:0] ra);
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (m_hc(q[i]) && q[i].cdst == ra) return {1'b1, W'(q[i].carry)};
      if (m_eff(q[i]) == ra) return {1'b1, q[i].data};
    end
    return '0;
  endfunction

  task automatic drive(input logic v, input logic [1:0] k, input logic [D-1:0] d,
                       input logic [D-1:0] c, input logic [W-1:0] dt, input logic cy);
    in_valid = v; in_kind = k; in_dst = d; in_carry_dst = c; in_data = dt; in_carry = cy;
  endtask

  task automatic tick();
    ent_t n;
    bit   do_push;
    @(posedge Clk);
    if (Reset) begin
      q.delete();
      half_done = 0;
    end else begin
      do_push = in_valid && (q.size() < DEPTH);
      n = '{kind: in_kind, dst: in_dst, cdst: in_carry_dst, data: in_data, carry: in_carry};
      if (q.size() > 0 && !wb_stall) begin
`ifdef REGFILE_WB_SPLIT_CARRY_EN
        if (!half_done && m_hc(q[0])) half_done = 1;
        else begin void'(q.pop_front()); half_done = 0; end
`else
        void'(q.pop_front());
`endif
      end
      if (do_push) q.push_back(n);
    end
    #1;
  endtask

  task automatic drain();
    drive(0, 2'b00, '0, '0, '0, 0);
    wb_stall = 0;
    for (int i = 0; i < 8 && q.size() > 0; i++) tick();
  endtask

  task automatic test_reset();
    Reset = 1; wb_stall = 0;
    drive(0, 2'b00, '0, '0, '0, 0);
    fwd_raddr_a = '0; fwd_raddr_accum = '0;
    tick(); tick();
    #3;
    n_checks++; if (wport !== '0) $display("FAIL reset_wport got %h want 0", wport); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", in_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if ({fwd_hit_a, fwd_data_a, fwd_hit_accum, fwd_data_accum} !== '0)
      $display("FAIL reset_fwd got %b/%h %b/%h want 0", fwd_hit_a, fwd_data_a, fwd_hit_accum, fwd_data_accum);
    else n_pass++;
    Reset = 0;
  endtask

  task automatic test_single_add();
    drive(1, 2'b10, 4'd0, 4'd5, 8'h3C, 1);
    tick();
    drive(0, 2'b00, '0, '0, '0, 0);
    #3;
    n_checks++; if (wport !== exp_wport()) $display("FAIL add_wport got %h want %h", wport, exp_wport()); else n_pass++;
`ifndef REGFILE_WB_SPLIT_CARRY_EN
    n_checks++; if (wport !== {1'b1, 1'b1, 2'b10, 4'd0, 4'd5, 8'h3C, 1'b1})
      $display("FAIL add_const got %h want %h", wport, {1'b1, 1'b1, 2'b10, 4'd0, 4'd5, 8'h3C, 1'b1});
    else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL add_busy_hi got %b want 1", busy); else n_pass++;
    tick(); #3;
    n_checks++; if (busy !== 1'b0) $display("FAIL add_busy_lo got %b want 0", busy); else n_pass++;
`endif
    drain();
  endtask

  task automatic test_stall_fwd();
    wb_stall = 1;
    drive(1, 2'b11, 4'd3, 4'd0, 8'hAA, 0); tick();
    drive(1, 2'b11, 4'd3, 4'd0, 8'h55, 0); tick();
    drive(0, 2'b00, '0, '0, '0, 0);
    fwd_raddr_a = 4'd3;
    #3;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_ready got %b want 0", in_ready); else n_pass++;
    n_checks++; if ({fwd_hit_a, fwd_data_a} !== {1'b1, 8'h55})
      $display("FAIL stall_fwd got %b/%h want 1/55", fwd_hit_a, fwd_data_a); else n_pass++;
    n_checks++; if (WriteEn !== 1'b0) $display("FAIL stall_we got %b want 0", WriteEn); else n_pass++;
    tick();
    wb_stall = 0;
    #3;
    n_checks++; if ({WriteEn, DataIn} !== {1'b1, 8'hAA}) $display("FAIL rel_first got %b/%h want 1/AA", WriteEn, DataIn); else n_pass++;
    n_checks++; if (wport !== exp_wport()) $display("FAIL rel_first_wp got %h want %h", wport, exp_wport()); else n_pass++;
    tick(); #3;
    n_checks++; if ({WriteEn, DataIn} !== {1'b1, 8'h55}) $display("FAIL rel_second got %b/%h want 1/55", WriteEn, DataIn); else n_pass++;
    tick(); #3;
    n_checks++; if (busy !== 1'b0) $display("FAIL rel_idle got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_carry_wins();
    wb_stall = 1;
    drive(1, 2'b01, 4'd7, 4'd7, 8'hF0, 1); tick();
    drive(0, 2'b00, '0, '0, '0, 0);
    fwd_raddr_a = 4'd7; fwd_raddr_accum = 4'd7;
    #3;
    n_checks++; if ({fwd_hit_a, fwd_data_a} !== {1'b1, 8'h01})
      $display("FAIL carry_win_a got %b/%h want 1/01", fwd_hit_a, fwd_data_a); else n_pass++;
    n_checks++; if ({fwd_hit_accum, fwd_data_accum} !== {1'b1, 8'h01})
      $display("FAIL carry_win_acc got %b/%h want 1/01", fwd_hit_accum, fwd_data_accum); else n_pass++;
    fwd_raddr_accum = 4'd0;
    tick(); #3;
    n_checks++; if ({fwd_hit_accum, fwd_data_accum} !== exp_fwd(4'd0))
      $display("FAIL acc_nohit got %b/%h want %h", fwd_hit_accum, fwd_data_accum, exp_fwd(4'd0)); else n_pass++;
    drain();
  endtask

  task automatic test_reset_midop();
    wb_stall = 1;
    drive(1, 2'b10, 4'd0, 4'd4, 8'h11, 1); tick();
    drive(1, 2'b11, 4'd6, 4'd0, 8'h22, 0); tick();
    drive(0, 2'b00, '0, '0, '0, 0);
    fwd_raddr_a = 4'd6;
    Reset = 1; tick(); #3;
    n_checks++; if (wport !== '0) $display("FAIL rst_mid_wport got %h want 0", wport); else n_pass++;
    n_checks++; if ({in_ready, busy, fwd_hit_a, fwd_hit_accum} !== 4'b1000)
      $display("FAIL rst_mid_flags got %b want 1000", {in_ready, busy, fwd_hit_a, fwd_hit_accum}); else n_pass++;
    Reset = 0; wb_stall = 0;
    tick(); #3;
    n_checks++; if (WriteEn !== 1'b0) $display("FAIL rst_stale got %b want 0", WriteEn); else n_pass++;
  endtask

`ifdef REGFILE_WB_SPLIT_CARRY_EN
  task automatic test_split();
    wb_stall = 0;
    drive(1, 2'b01, 4'd2, 4'd9, 8'h81, 1); tick();
    drive(0, 2'b00, '0, '0, '0, 0);
    #3;
    n_checks++; if ({WriteEn, addrFlag, Waddr, DataIn, writeEnCarryOut} !== {1'b1, 2'b11, 4'd2, 8'h81, 1'b0})
      $display("FAIL split_data got %b %b %h %h %b", WriteEn, addrFlag, Waddr, DataIn, writeEnCarryOut); else n_pass++;
    tick(); #3;
    n_checks++; if ({WriteEn, addrFlag, Waddr, DataIn, writeEnCarryOut} !== {1'b1, 2'b11, 4'd9, 8'h01, 1'b0})
      $display("FAIL split_carry got %b %b %h %h %b", WriteEn, addrFlag, Waddr, DataIn, writeEnCarryOut); else n_pass++;
    drain();
  endtask
`endif

  task automatic test_back_to_back();
    logic [W-1:0] sent [20];
    logic [1:0]   k;
    int           writes = 0;
    wb_stall = 0;
    for (int i = 0; i <= 20; i++) begin
      if (i < 20) begin
`ifdef REGFILE_WB_SPLIT_CARRY_EN
        k = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
`else
        k = 2'($urandom);
`endif
        sent[i] = W'($urandom);
        drive(1, k, D'($urandom), D'($urandom), sent[i], 1'($urandom));
      end else begin
        drive(0, 2'b00, '0, '0, '0, 0);
      end
      #3;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready i=%0d got %b want 1", i, in_ready); else n_pass++;
      n_checks++; if (wport !== exp_wport()) $display("FAIL b2b_wport i=%0d got %h want %h", i, wport, exp_wport()); else n_pass++;
      if (WriteEn === 1'b1 && writes < 20) begin
        n_checks++; if (DataIn !== sent[writes]) $display("FAIL b2b_order n=%0d got %h want %h", writes, DataIn, sent[writes]); else n_pass++;
        writes++;
      end
      tick();
    end
    n_checks++; if (writes != 20) $display("FAIL b2b_count got %0d want 20", writes); else n_pass++;
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 9) < 6, 2'($urandom), D'($urandom_range(0, 3)), D'($urandom_range(0, 3)),
            W'($urandom), 1'($urandom));
      wb_stall        = ($urandom_range(0, 3) == 0);
      fwd_raddr_a     = D'($urandom_range(0, 3));
      fwd_raddr_accum = D'($urandom_range(0, 3));
      #3;
      n_checks++; if (in_ready !== (q.size() < DEPTH)) $display("FAIL rnd_ready i=%0d got %b want %b", i, in_ready, q.size() < DEPTH); else n_pass++;
      n_checks++; if (wport !== exp_wport()) $display("FAIL rnd_wport i=%0d got %h want %h", i, wport, exp_wport()); else n_pass++;
      n_checks++; if (busy !== (q.size() != 0)) $display("FAIL rnd_busy i=%0d got %b want %b", i, busy, q.size() != 0); else n_pass++;
      n_checks++; if ({fwd_hit_a, fwd_data_a} !== exp_fwd(fwd_raddr_a))
        $display("FAIL rnd_fwd_a i=%0d got %b/%h want %h", i, fwd_hit_a, fwd_data_a, exp_fwd(fwd_raddr_a)); else n_pass++;
      n_checks++; if ({fwd_hit_accum, fwd_data_accum} !== exp_fwd(fwd_raddr_accum))
        $display("FAIL rnd_fwd_acc i=%0d got %b/%h want %h", i, fwd_hit_accum, fwd_data_accum, exp_fwd(fwd_raddr_accum)); else n_pass++;
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_stall_fwd();
    test_carry_wins();
    test_reset_midop();
`ifdef REGFILE_WB_SPLIT_CARRY_EN
    test_split();
`endif
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writeback stage that drives the register file's write port: WriteEn, writeEnCarryOut, addrFlag, Waddr, waddrCarryOut, DataIn, carryOutData.
- Accepts ALU/mov results on a valid/ready handshake and buffers them in a 2-entry FIFO.
- Presents the FIFO head to the register file and provides read-forwarding of pending writes for both register-file read addresses.
- Sits between the execute stage and the register file.

Parameters:
W, 8, data path width
D, 4, register pointer width
DEPTH, 2, buffer entries (power of 2, >=2)

Ports:
Clk  input  1  clock, all state on posedge
Reset  input  1  synchronous, active-high reset
in_valid  input  1  result offered
in_ready  output  1  buffer can accept (not full)
in_kind  input  2  00 acc, 01 sll, 10 add, 11 mov
in_dst  input  D  data destination (used by kinds 01 and 11)
in_carry_dst  input  D  carry destination (used by kinds 01 and 10)
in_data  input  W  result value
in_carry  input  1  carry-out bit
wb_stall  input  1  hold head entry; no write this cycle
WriteEn  output  1  register file write enable
writeEnCarryOut  output  1  carry write enable
addrFlag  output  2  write form
Waddr  output  D  data write address
waddrCarryOut  output  D  carry write address
DataIn  output  W  write data
carryOutData  output  1  carry write data
fwd_raddr_a  input  D  read address A
fwd_raddr_accum  input  D  accumulator read address
fwd_hit_a  output  1  pending write targets fwd_raddr_a
fwd_data_a  output  W  forwarded value for A
fwd_hit_accum  output  1  pending write targets fwd_raddr_accum
fwd_data_accum  output  W  forwarded value for the accumulator address
busy  output  1  buffer non-empty or split FSM not in IDLE

Behaviour:
- Reset: clears the FIFO pointers and count, and sets the FSM to IDLE. From the first Clk edge with Reset high, all outputs are 0, except in_ready = 1. Reset mid-operation drops every pending entry, including a half-done split write.
- Accept: an entry is pushed when in_valid && in_ready.
- in_ready = (count < DEPTH). It is combinational from registered state and does not depend on the same-cycle pop.
- Latency: an entry accepted at edge N drives the write port during cycle N+1 at the earliest. Write-port outputs are combinational from the head entry and FSM state.
- Effective data destination: in_dst for kinds 01/11; register 0 for kinds 00/10.
- Carry destination is valid only for kinds 01/10. The carry value is {W-1 zeros, carry}.
- Normal mode (macro off):
  - Non-empty and !wb_stall: WriteEn = 1, addrFlag = kind, Waddr = in_dst, DataIn = data, carryOutData = carry.
  - writeEnCarryOut = 1 only for kinds 01/10, with waddrCarryOut = carry_dst.
  - The head is popped at the end of the cycle.
- wb_stall = 1 or empty: WriteEn = 0, writeEnCarryOut = 0, no pop; other outputs are 0.
- Simultaneous push and pop at count == DEPTH cannot occur, because in_ready = 0. Push and pop at count 1 leaves count 1. Pointers wrap modulo DEPTH.
- Forwarding:
  - Scans all valid entries, including the head being written this cycle.
  - The youngest match wins.
  - Within one entry, a carry-destination match wins over a data-destination match, matching the register file's write ordering.
  - fwd_data_* = 0 when there is no hit.
  - In split mode, a head whose data half is already written still forwards both halves.

Optional Feature:
- Macro: REGFILE_WB_SPLIT_CARRY_EN. It serializes dual writes for a single-write-port register file.
- Defined: FSM states IDLE, DATA, CARRY.
  - IDLE→DATA when non-empty.
  - DATA drives addrFlag = 11, Waddr = effective data dst, writeEnCarryOut = 0.
  - In DATA with !wb_stall: a kind 01/10 entry goes to CARRY; otherwise the head is popped and the FSM goes to IDLE, or stays in DATA if another entry remains.
  - CARRY drives addrFlag = 11, Waddr = carry_dst, DataIn = {0, carry}. With !wb_stall it pops, then goes to DATA if entries remain, else IDLE.
  - wb_stall holds state. writeEnCarryOut is never 1.
- Undefined: no FSM; single-cycle dual write as above.

Decomposition:
- Shared package:
  - kind encodings: KIND_ACC = 2'b00, KIND_SLL = 2'b01, KIND_ADD = 2'b10, KIND_MOV = 2'b11.
  - ACC_REG = 0.
  - W/D defaults.
- Sub-module wb_fifo: the generic DEPTH x entry FIFO with push/pop/count and entry-vector output for the forwarding scan.

Test Plan:
- Push {kind 10, data 8'h3C, carry 1, carry_dst 4'd5} with no stall → next cycle WriteEn = 1, addrFlag = 10, DataIn = 3C, writeEnCarryOut = 1, waddrCarryOut = 5, carryOutData = 1; busy falls the cycle after.
- Hold wb_stall = 1 and push 2 movs (dst 3, 8'hAA; dst 3, 8'h55) → in_ready = 0; fwd_raddr_a = 3 gives hit with 55. Release the stall → two writes on consecutive cycles, AA then 55.
- sll with dst = carry_dst = 7, data 8'hF0, carry 1 → fwd on 7 returns 8'h01 (carry wins).
- Assert Reset with 2 entries pending and the stall active → from that edge WriteEn = 0, in_ready = 1, no hits, busy = 0; no stale write after the stall releases.
- Split macro defined: push sll {dst 2, 8'h81, carry 1, carry_dst 9} → cycle 1 writes Waddr = 2 with 81, cycle 2 writes Waddr = 9 with 01; addrFlag = 11 and writeEnCarryOut = 0 in both cycles.
- Back-to-back pushes every cycle with no stall for 20 cycles → 20 writes in order, in_ready stays 1, no entry lost across pointer wrap.
